// File: rtl/crc_pkg.sv
// Shared CRC-16 definitions for the transmit framer and the receive-side checker.
// Pure declarations; no timing.
// No flow control here; callers own their handshakes.
package crc_pkg;

   localparam int               CRC_W      = 16;
   localparam logic [CRC_W-1:0] CRC16_POLY = 16'h1021;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      CRC
   } crc_state_t;

   // One serial step of the MSB-first CRC: the feedback bit decides whether the polynomial is folded in.
   function automatic logic [CRC_W-1:0] crc16_step(input logic [CRC_W-1:0] crc,
                                                   input logic             din,
                                                   input logic [CRC_W-1:0] poly = CRC16_POLY);
      logic fb;
      fb = crc[CRC_W-1] ^ din;
      return {crc[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
   endfunction

endpackage

// File: rtl/crc16_lfsr.sv
// 16-bit CRC register: accumulate payload bits, or shift the remainder out MSB first.
// Result visible on sout the cycle after an enabled step.
// Only advances when en is high; the owner stalls it by holding en low.
module crc16_lfsr import crc_pkg::*; #(
   parameter logic [CRC_W-1:0] POLY = CRC16_POLY
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic shift,
   input  logic din,
   output logic sout
);

   logic [CRC_W-1:0] crc;

   // Shift mode drains the remainder with zero fill; update mode folds din in, optionally from a zero seed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc <= '0;
      end else if (en) begin
         if (shift) begin
            crc <= {crc[CRC_W-2:0], 1'b0};
         end else begin
            crc <= crc16_step(clr ? '0 : crc, din, POLY);
         end
      end else if (clr) begin
         crc <= '0;
      end
   end

   assign sout = crc[CRC_W-1];

endmodule

// File: rtl/encoder_crc.sv
// Serial CRC-16 framer: forwards NUM_BITS payload bits and appends the 16-bit CRC MSB first.
// One registered output stage: an accepted bit appears on odata the next cycle.
// iready drops during the CRC tail and whenever the output stage is held by oready low.
module encoder_crc #(
   parameter int                             NUM_BITS = 1904,
   parameter int                             CRC_W    = crc_pkg::CRC_W,
   parameter logic [crc_pkg::CRC_W-1:0]      POLY     = crc_pkg::CRC16_POLY,
   parameter int                             CNT_W    = $clog2(NUM_BITS + CRC_W)
) (
   input  logic clk,
   input  logic rst,
   input  logic ival,
   input  logic idata,
   input  logic isop,
   output logic iready,
   output logic odata,
   output logic oval,
   input  logic oready,
   output logic osop,
   output logic oeop,
   output logic ocrc_phase,
   output logic frame_abort
);

   import crc_pkg::*;

   localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(NUM_BITS - 1);
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(NUM_BITS + CRC_W - 1);
   // A one-bit payload has nothing left to collect after its start bit.
   localparam crc_state_t       AFTER_SOP = (NUM_BITS == 1) ? CRC : DATA;

   crc_state_t       state;
   logic [CNT_W-1:0] cnt;

   logic stage_free;
   logic acc;
   logic start;
   logic data_acc;
   logic crc_emit;
   logic crc_msb;

   assign stage_free = ~oval | oready;
   assign iready     = (state != CRC) & stage_free;
   assign acc        = ival & iready;
   // isop restarts the CRC both from IDLE and mid-payload.
   assign start      = acc & isop;
   assign data_acc   = acc & ~isop & (state == DATA);
   assign crc_emit   = (state == CRC) & stage_free;

   crc16_lfsr #(
      .POLY (POLY)
   ) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .clr   (start),
      .en    (start | data_acc | crc_emit),
      .shift (crc_emit),
      .din   (idata),
      .sout  (crc_msb)
   );

   // Frame sequencing and the registered output stage; the stage holds whenever downstream stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         oval        <= 1'b0;
         odata       <= 1'b0;
         osop        <= 1'b0;
         oeop        <= 1'b0;
         ocrc_phase  <= 1'b0;
         frame_abort <= 1'b0;
      end else begin
         frame_abort <= 1'b0;
         if (stage_free) begin
            oval <= 1'b0;
         end
         case (state)
            IDLE: begin
               // Bits arriving without isop are dropped here.
               if (start) begin
                  oval       <= 1'b1;
                  odata      <= idata;
                  osop       <= 1'b1;
                  oeop       <= 1'b0;
                  ocrc_phase <= 1'b0;
                  cnt        <= CNT_W'(1);
                  state      <= AFTER_SOP;
               end
            end
            DATA: begin
               if (acc) begin
                  oval       <= 1'b1;
                  odata      <= idata;
                  oeop       <= 1'b0;
                  ocrc_phase <= 1'b0;
                  if (isop) begin
                     // Abandon the current frame without a CRC and treat this bit as a new bit 0.
                     frame_abort <= 1'b1;
                     osop        <= 1'b1;
                     cnt         <= CNT_W'(1);
                     state       <= AFTER_SOP;
                  end else begin
                     osop <= 1'b0;
                     cnt  <= cnt + CNT_W'(1);
                     if (cnt == LAST_DATA) begin
                        state <= CRC;
                     end
                  end
               end
            end
            CRC: begin
               if (stage_free) begin
                  oval       <= 1'b1;
                  odata      <= crc_msb;
                  osop       <= 1'b0;
                  ocrc_phase <= 1'b1;
                  if (cnt == LAST_BIT) begin
                     // The shifter has zero-filled itself by now, so the next frame starts clean.
                     oeop  <= 1'b1;
                     cnt   <= '0;
                     state <= IDLE;
                  end else begin
                     oeop <= 1'b0;
                     cnt  <= cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_encoder_crc.sv
// Scoreboard bench for encoder_crc: a 1904-bit instance and a 72-bit instance share one driver.
// Expected output bits are queued when the driver sees an input accepted and popped at output handshakes.
// A receive-side CRC check runs over every observed frame.
module tb_encoder_crc;

   localparam int NA = 1904;
   localparam int NB = 72;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic sel;
   logic ival, idata, isop, oready;
   logic ival_a, ival_b;
   logic iready_a, odata_a, oval_a, osop_a, oeop_a, ocph_a, fa_a;
   logic iready_b, odata_b, oval_b, osop_b, oeop_b, ocph_b, fa_b;
   logic iready_m, odata_m, oval_m, osop_m, oeop_m, ocph_m, fa_m;

   assign ival_a   = ival & ~sel;
   assign ival_b   = ival & sel;
   assign iready_m = sel ? iready_b : iready_a;
   assign odata_m  = sel ? odata_b  : odata_a;
   assign oval_m   = sel ? oval_b   : oval_a;
   assign osop_m   = sel ? osop_b   : osop_a;
   assign oeop_m   = sel ? oeop_b   : oeop_a;
   assign ocph_m   = sel ? ocph_b   : ocph_a;
   assign fa_m     = sel ? fa_b     : fa_a;

   encoder_crc #(.NUM_BITS(NA)) u_dut_a (
      .clk(clk), .rst(rst), .ival(ival_a), .idata(idata), .isop(isop), .iready(iready_a),
      .odata(odata_a), .oval(oval_a), .oready(oready), .osop(osop_a), .oeop(oeop_a),
      .ocrc_phase(ocph_a), .frame_abort(fa_a));

   encoder_crc #(.NUM_BITS(NB)) u_dut_b (
      .clk(clk), .rst(rst), .ival(ival_b), .idata(idata), .isop(isop), .iready(iready_b),
      .odata(odata_b), .oval(oval_b), .oready(oready), .osop(osop_b), .oeop(oeop_b),
      .ocrc_phase(ocph_b), .frame_abort(fa_b));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] step(input logic [15:0] c, input logic b);
      return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
   endfunction

   logic [3:0]  sb[$];
   logic [15:0] mcrc;
   logic        pay [0:NA-1];

   logic [15:0] rx_rem, cap, last_crc;
   logic [3:0]  mon_e;
   logic        mon_b;
   int          frames_done = 0, rx_err = 0, abort_cnt = 0, ir_low = 0, crc_seen = 0;
   bit          flip_pending = 0;
   bit          rand_rdy = 0;

   // Output monitor: scoreboard compare plus receive-side CRC check.
   always @(negedge clk) begin
      if (!rst) begin
         if (fa_m) abort_cnt++;
         if (!iready_m) ir_low++;
         if (oval_m && oready) begin
            if (sb.size() == 0) begin
               chk("unexpected_out", 1, 0);
            end else begin
               mon_e = sb.pop_front();
               chk("obit{d,sop,eop,crc}", {odata_m, osop_m, oeop_m, ocph_m}, mon_e);
            end
            mon_b = odata_m;
            if (osop_m && flip_pending) begin
               mon_b = ~mon_b;
               flip_pending = 0;
            end
            rx_rem = step(osop_m ? 16'h0000 : rx_rem, mon_b);
            if (osop_m) crc_seen = 0;
            if (ocph_m) begin
               cap = {cap[14:0], odata_m};
               crc_seen++;
            end
            if (oeop_m) begin
               last_crc = cap;
               frames_done++;
               if (rx_rem != 16'h0000) rx_err++;
            end
         end
      end
   end

   // Random downstream stalls when enabled.
   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         oready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic send_bit(input logic d, input logic sop, input int gap_max);
      int waited;
      if (gap_max > 0) begin
         repeat ($urandom_range(0, gap_max)) begin
            @(posedge clk);
            #1;
         end
      end
      ival = 1'b1; idata = d; isop = sop; waited = 0;
      forever begin
         @(negedge clk);
         if (iready_m) begin
            sb.push_back({d, sop, 2'b00});
            mcrc = step(sop ? 16'h0000 : mcrc, d);
            @(posedge clk);
            #1;
            ival = 1'b0; isop = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
         waited++;
         if (waited > 4000) begin
            chk("accept_timeout", 0, 1);
            ival = 1'b0; isop = 1'b0;
            return;
         end
      end
   endtask

   task automatic push_crc();
      for (int k = 15; k >= 0; k--) sb.push_back({mcrc[k], 1'b0, (k == 0), 1'b1});
   endtask

   task automatic send_frame(input int nb, input int gap_max, input bit with_crc);
      for (int i = 0; i < nb; i++) send_bit(pay[i], (i == 0), gap_max);
      if (with_crc) push_crc();
   endtask

   task automatic drain();
      int w;
      w = 0;
      while ((sb.size() != 0 || oval_m) && w < 8000) begin
         @(posedge clk);
         #1;
         w++;
      end
      if (w >= 8000) chk("drain_timeout", 0, 1);
   endtask

   task automatic rand_pay(input int nb);
      for (int i = 0; i < nb; i++) pay[i] = 1'($urandom_range(0, 1));
   endtask

   initial begin
      int fd0, rx0, w;
      logic [7:0] ch;
      sel = 1'b0; ival = 1'b0; idata = 1'b0; isop = 1'b0; oready = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_oval_a", oval_a, 0);
      chk("rst_osop_a", osop_a, 0);
      chk("rst_oeop_a", oeop_a, 0);
      chk("rst_ocrc_a", ocph_a, 0);
      chk("rst_odata_a", odata_a, 0);
      chk("rst_abort_a", fa_a, 0);
      chk("rst_iready_a", iready_a, 1);
      chk("rst_oval_b", oval_b, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // All-zero 1904-bit payload.
      for (int i = 0; i < NA; i++) pay[i] = 1'b0;
      ir_low = 0;
      send_frame(NA, 0, 1);
      drain();
      chk("zero_crc", last_crc, 16'h0000);
      chk("zero_iready_low_cycles", ir_low, 16);

      // Single 1 in the last payload bit, then the same bit cleared.
      pay[NA-1] = 1'b1;
      send_frame(NA, 0, 1);
      drain();
      chk("last_bit_one_crc", last_crc, 16'h1021);
      pay[NA-1] = 1'b0;
      send_frame(NA, 0, 1);
      drain();
      chk("last_bit_zero_crc", last_crc, 16'h0000);

      // Restart at payload bit 500.
      fd0 = frames_done; abort_cnt = 0;
      rand_pay(NA);
      send_frame(500, 0, 0);
      rand_pay(NA);
      send_frame(NA, 0, 1);
      drain();
      chk("abort_pulses", abort_cnt, 1);
      chk("abort_eop_count", frames_done - fd0, 1);
      chk("abort_crc", last_crc, mcrc);
      chk("abort_rx_err", rx_err, 0);

      // 72-bit instance: ASCII "123456789" MSB first.
      sel = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 9; k++) begin
         ch = 8'(8'h31 + k);
         for (int j = 0; j < 8; j++) pay[k*8+j] = ch[7-j];
      end
      send_bit(pay[0], 1'b1, 0);
      chk("latency_oval", oval_m, 1);
      chk("latency_osop", osop_m, 1);
      for (int i = 1; i < NB; i++) send_bit(pay[i], 1'b0, 0);
      push_crc();
      drain();
      chk("xmodem_check", last_crc, 16'h31c3);

      // 100 random frames back to back with input gaps and output stalls.
      fd0 = frames_done; rx0 = rx_err;
      rand_rdy = 1;
      for (int f = 0; f < 100; f++) begin
         rand_pay(NB);
         send_frame(NB, 2, 1);
      end
      drain();
      chk("rand_frames", frames_done - fd0, 100);
      chk("rand_rx_err", rx_err - rx0, 0);

      // One corrupted channel bit must be caught by the checker.
      flip_pending = 1;
      rand_pay(NB);
      send_frame(NB, 1, 1);
      drain();
      chk("flip_rx_err", rx_err - rx0, 1);
      rand_rdy = 0;
      @(posedge clk);
      #2;
      oready = 1'b1;
      @(posedge clk);
      #1;

      // Asynchronous reset in the middle of the CRC tail.
      rand_pay(NB);
      send_frame(NB, 0, 1);
      w = 0;
      while (crc_seen < 5 && w < 200) begin
         @(posedge clk);
         #1;
         w++;
      end
      chk("mid_crc_reached", (crc_seen >= 5), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_oval", oval_b, 0);
      chk("async_rst_ocrc", ocph_b, 0);
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      rx0 = rx_err;
      rand_pay(NB);
      send_frame(NB, 0, 1);
      drain();
      chk("post_rst_crc", last_crc, mcrc);
      chk("post_rst_rx_err", rx_err - rx0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
